baud_gen_frac: RTL
==================

// Module: baud_gen_frac
// PURPOSE
//  Runtime-programmable fractional baud generator; next generation of the fixed-divider UART tick source.
//  Produces an oversample tick (os_tick) and a bit tick (baud_tick = every OVERSAMPLE os_ticks).
//  Fractional accumulator keeps long-term baud error near zero.
//  Feeds UART TX (baud_tick) and RX (os_tick + sync_clr on start-bit edge).
// PARAMETERS
//  CLOCK_FREQ    50000000  system clock frequency, Hz
//  BAUD_RATE     9600      reset-default baud rate
//  OVERSAMPLE    16        os_ticks per bit; power of 2, >=4
//  DIV_W         16        width of integer divisor
//  FRAC_W        4         width of fractional divisor (1/2^FRAC_W steps)
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  en           in   1       run enable; low = counters cleared, no ticks
//  sync_clr     in   1       sync phase restart (RX start-bit alignment)
//  div_load     in   1       1-cycle strobe: capture div_int_in/div_frac_in
//  div_int_in   in   DIV_W   integer clocks per os_tick
//  div_frac_in  in   FRAC_W  fractional clocks per os_tick, x 2^-FRAC_W
//  os_tick      out  1       1-cycle oversample pulse, registered
//  baud_tick    out  1       1-cycle bit pulse, coincident with every OVERSAMPLE-th os_tick
//  cur_div_int  out  DIV_W   active integer divisor
//  cur_div_frac out  FRAC_W  active fractional divisor
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - pre_cnt, os_cnt, frac_acc, carry, shadow-valid = 0; os_tick = baud_tick = 0.
//  - cur_div_int  = CLOCK_FREQ / (BAUD_RATE*OVERSAMPLE)
//  - cur_div_frac = ((CLOCK_FREQ<<FRAC_W) / (BAUD_RATE*OVERSAMPLE)) mod 2^FRAC_W
//  Prescaler:
//  - pre_cnt counts 0..P-1, P = cur_div_int + carry.
//  - At pre_cnt = P-1: pre_cnt <= 0; os_tick <= 1 next cycle. os_tick spacing is exactly P clocks.
//  - On each os_tick event: sum = frac_acc + cur_div_frac (FRAC_W+1 bits); frac_acc <= sum[FRAC_W-1:0]; carry <= sum[FRAC_W].
//  Oversample counter:
//  - os_cnt increments on each os_tick event, wraps OVERSAMPLE-1 -> 0.
//  - baud_tick asserted in the same cycle as os_tick when os_cnt was OVERSAMPLE-1.
//  - Bit period = OVERSAMPLE*cur_div_int + (number of carries) clocks.
//  Divisor update:
//  - div_load captures inputs into a shadow register.
//  - Shadow is applied at the next os_tick event boundary, so the current period is never truncated or stretched.
//  - If en=0, shadow is applied on the cycle after div_load.
//  - div_int_in < 2 is clamped to 2.
//  - A second div_load before apply overwrites the shadow; last write wins.
//  Control priority: rst_n > en=0 > sync_clr > tick/count.
//  - en=0: pre_cnt, os_cnt, frac_acc, carry held at 0; ticks 0. First os_tick comes cur_div_int clocks after en rises.
//  - sync_clr=1: same clear as en=0 for that cycle; any tick due that cycle is suppressed. The next os_tick comes cur_div_int clocks after sync_clr falls.
//  - Pending shadow is applied on sync_clr.
//  - sync_clr and div_load in the same cycle: both take effect; the new divisor is used for the first period.
//  No FSM beyond counters: states are IDLE (en=0) and RUN. sync_clr behaves as RUN restarted at phase 0.
// CONFIGURATION
//  BAUD_GEN_HALF_TICK_EN defined:
//  - Adds output half_tick (out, 1). It pulses with os_tick when os_cnt was OVERSAMPLE/2-1, i.e. mid-bit, for the RX sampler.
//  - Cleared by reset, en=0 and sync_clr like the other ticks.
//  BAUD_GEN_HALF_TICK_EN undefined: the port and its logic are absent; all other behaviour is identical.
// TESTING
//  (defaults 50MHz/9600/16 -> div 325, frac 8)
//  1. Reset, en=1 -> cur_div=325/8.
//     - os_tick spacing alternates 325,326 starting with 325.
//     - baud_tick every 5208 clocks; 100 bits = 520800 +/- 0 clocks.
//  2. Load div_int_in=27, frac=2 mid-period:
//     - Current period completes at old divisor; next period uses the new one.
//     - Bit period 434 clocks (115200 baud).
//  3. sync_clr pulse at os_cnt=7:
//     - No tick that cycle.
//     - Next os_tick exactly 325 clocks after sync_clr falls.
//     - baud_tick after 16 os_ticks.
//  4. Load div_int_in=1, frac=0 -> cur_div_int=2; os_tick every 2 clocks; baud_tick every 32 clocks.
//  5. Assert rst_n=0 mid-bit, asynchronously between clock edges:
//     - Ticks go 0 immediately; cur_div returns to 325/8.
//     - After release with en=1, first os_tick at 325 clocks.
//  6. BAUD_GEN_HALF_TICK_EN defined: half_tick occurs 8 os_ticks after each baud_tick, i.e. 2604 +/- 1 clocks at default divisor.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Runtime-programmable fractional baud generator: os_tick every cur_div_int(+carry) clocks, baud_tick every OVERSAMPLE os_ticks.
// Optional mid-bit half_tick output is enabled by defining BAUD_GEN_HALF_TICK_EN.
module baud_gen_frac #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              div_load,
  input  logic [DIV_W-1:0]  div_int_in,
  input  logic [FRAC_W-1:0] div_frac_in,
  output logic              os_tick,
  output logic              baud_tick,
`ifdef BAUD_GEN_HALF_TICK_EN
  output logic              half_tick,
`endif
  output logic [DIV_W-1:0]  cur_div_int,
  output logic [FRAC_W-1:0] cur_div_frac
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam longint unsigned OS_RATE    = longint'(BAUD_RATE) * longint'(OVERSAMPLE);
  localparam longint unsigned DEF_INT_L  = longint'(CLOCK_FREQ) / OS_RATE;
  localparam longint unsigned DEF_FRAC_L = (longint'(CLOCK_FREQ) << FRAC_W) / OS_RATE;
  localparam logic [DIV_W-1:0]  DEF_INT  = DEF_INT_L[DIV_W-1:0];
  localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_FRAC_L[FRAC_W-1:0];
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]   OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);

  logic [DIV_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
  logic              carry_q, carry_d;
  logic              os_tick_q, os_tick_d;
  logic              baud_tick_q, baud_tick_d;
  logic [DIV_W-1:0]  cur_div_int_q, cur_div_int_d;
  logic [FRAC_W-1:0] cur_div_frac_q, cur_div_frac_d;
  logic [DIV_W-1:0]  shadow_int_q, shadow_int_d;
  logic [FRAC_W-1:0] shadow_frac_q, shadow_frac_d;
  logic              shadow_valid_q, shadow_valid_d;

  logic [DIV_W-1:0]  div_int_clamped;
  logic [DIV_W:0]    period_m1;
  logic [FRAC_W:0]   frac_sum;
  logic              wrap_hit;

  assign div_int_clamped = (div_int_in < DIV_W'(2)) ? DIV_W'(2) : div_int_in;
  assign period_m1 = {1'b0, cur_div_int_q} + {{DIV_W{1'b0}}, carry_q} - {{DIV_W{1'b0}}, 1'b1};
  assign wrap_hit  = ({1'b0, pre_cnt_q} == period_m1);
  assign frac_sum  = {1'b0, frac_acc_q} + {1'b0, cur_div_frac_q};

`ifdef BAUD_GEN_HALF_TICK_EN
  logic half_tick_q, half_tick_d;
`endif

  always_comb begin
    pre_cnt_d      = pre_cnt_q;
    os_cnt_d       = os_cnt_q;
    frac_acc_d     = frac_acc_q;
    carry_d        = carry_q;
    os_tick_d      = 1'b0;
    baud_tick_d    = 1'b0;
    cur_div_int_d  = cur_div_int_q;
    cur_div_frac_d = cur_div_frac_q;
    shadow_int_d   = shadow_int_q;
    shadow_frac_d  = shadow_frac_q;
    shadow_valid_d = shadow_valid_q;
`ifdef BAUD_GEN_HALF_TICK_EN
    half_tick_d    = 1'b0;
`endif

    if (div_load) begin
      shadow_int_d   = div_int_clamped;
      shadow_frac_d  = div_frac_in;
      shadow_valid_d = 1'b1;
    end

    if (!en) begin
      pre_cnt_d  = '0;
      os_cnt_d   = '0;
      frac_acc_d = '0;
      carry_d    = 1'b0;
      if (shadow_valid_q) begin
        cur_div_int_d  = shadow_int_q;
        cur_div_frac_d = shadow_frac_q;
        shadow_valid_d = div_load;
      end
    end else if (sync_clr) begin
      // A load arriving with the restart governs the very first period.
      pre_cnt_d  = '0;
      os_cnt_d   = '0;
      frac_acc_d = '0;
      carry_d    = 1'b0;
      if (div_load) begin
        cur_div_int_d  = div_int_clamped;
        cur_div_frac_d = div_frac_in;
        shadow_valid_d = 1'b0;
      end else if (shadow_valid_q) begin
        cur_div_int_d  = shadow_int_q;
        cur_div_frac_d = shadow_frac_q;
        shadow_valid_d = 1'b0;
      end
    end else if (wrap_hit) begin
      pre_cnt_d   = '0;
      os_tick_d   = 1'b1;
      baud_tick_d = (os_cnt_q == OS_LAST);
`ifdef BAUD_GEN_HALF_TICK_EN
      half_tick_d = (os_cnt_q == OS_HALF);
`endif
      os_cnt_d    = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + 1'b1;
      frac_acc_d  = frac_sum[FRAC_W-1:0];
      carry_d     = frac_sum[FRAC_W];
      // Divisor changes only on a period boundary so no period is cut short.
      if (shadow_valid_q) begin
        cur_div_int_d  = shadow_int_q;
        cur_div_frac_d = shadow_frac_q;
        shadow_valid_d = div_load;
      end
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q      <= '0;
      os_cnt_q       <= '0;
      frac_acc_q     <= '0;
      carry_q        <= 1'b0;
      os_tick_q      <= 1'b0;
      baud_tick_q    <= 1'b0;
      cur_div_int_q  <= DEF_INT;
      cur_div_frac_q <= DEF_FRAC;
      shadow_int_q   <= DEF_INT;
      shadow_frac_q  <= DEF_FRAC;
      shadow_valid_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      os_cnt_q       <= os_cnt_d;
      frac_acc_q     <= frac_acc_d;
      carry_q        <= carry_d;
      os_tick_q      <= os_tick_d;
      baud_tick_q    <= baud_tick_d;
      cur_div_int_q  <= cur_div_int_d;
      cur_div_frac_q <= cur_div_frac_d;
      shadow_int_q   <= shadow_int_d;
      shadow_frac_q  <= shadow_frac_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end

`ifdef BAUD_GEN_HALF_TICK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_tick_q <= 1'b0;
    end else begin
      half_tick_q <= half_tick_d;
    end
  end

  assign half_tick = half_tick_q;
`endif

  assign os_tick      = os_tick_q;
  assign baud_tick    = baud_tick_q;
  assign cur_div_int  = cur_div_int_q;
  assign cur_div_frac = cur_div_frac_q;

endmodule
